// File: rtl/conv2d_ctrl_pkg.sv
// Shared constants for the conv2d layer sequencer: descriptor word map,
// ctrl-word bit positions and the sequencer state encoding.
package conv2d_ctrl_pkg;

    localparam int DATA_W = 32;

    localparam int WORD_CTRL = 0;
    localparam int WORD_RSVD = 1;
    localparam int WORD_GEOM = 2;
    localparam int WORD_CHAN = 3;
    localparam int WORD_KERN = 4;

    localparam int CTRL_START     = 0;
    localparam int CTRL_DONE      = 1;
    localparam int CTRL_CONV      = 2;
    localparam int CTRL_BN_RELU   = 3;
    localparam int CTRL_MAXPOOL   = 4;
    localparam int CTRL_LAYER_LSB = 5;
    localparam int CTRL_LAYER_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_GAP,
        ST_FINISH
    } seq_state_e;

    // Descriptor length: fixed header words followed by a MAX_K x MAX_K kernel.
    function automatic int words_per_layer(input int max_k);
        return WORD_KERN + max_k * max_k;
    endfunction

endpackage

// File: rtl/conv2d_desc_ram.sv
// Descriptor storage: one host read/write port and one accelerator read port,
// both with registered read data. Reads return the pre-write contents.
module conv2d_desc_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_h_we,
    input  logic [AW-1:0] i_h_addr,
    input  logic [DW-1:0] i_h_wdata,
    output logic [DW-1:0] o_h_rdata,
    input  logic [AW-1:0] i_a_addr,
    output logic [DW-1:0] o_a_rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] h_rdata_q;
    logic [DW-1:0] a_rdata_q;

    // The array itself is never reset; only the read registers are.
    always_ff @(posedge i_clk) begin
        if (i_h_we) begin
            mem_q[i_h_addr] <= i_h_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_rdata_q <= '0;
            a_rdata_q <= '0;
        end else begin
            h_rdata_q <= mem_q[i_h_addr];
            a_rdata_q <= mem_q[i_a_addr];
        end
    end

    assign o_h_rdata = h_rdata_q;
    assign o_a_rdata = a_rdata_q;

endmodule

// File: rtl/conv2d_layer_seq_ctrl.sv
// Multi-layer descriptor bank and sequencer for top_conv2d: serves the
// accelerator ctrl port and launches layers back-to-back on done writes.
module conv2d_layer_seq_ctrl #(
    parameter int NUM_LAYERS = 8,
    parameter int MAX_K      = 5,
    parameter int ACC_AW     = 5,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 0,
    localparam int LAYER_W   = $clog2(NUM_LAYERS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_host_we,
    input  logic [LAYER_W+ACC_AW-1:0] i_host_addr,
    input  logic [31:0]               i_host_wdata,
    output logic [31:0]               o_host_rdata,
    input  logic [LAYER_W:0]          i_num_layers,
    input  logic                      i_go,
    input  logic                      i_abort,
    input  logic [ACC_AW-1:0]         i_acc_addr,
    output logic [31:0]               o_acc_data,
    input  logic                      i_acc_we,
    input  logic [31:0]               i_acc_data,
    output logic                      o_busy,
    output logic [LAYER_W-1:0]        o_layer,
    output logic                      o_all_done,
    output logic                      o_err
);

    import conv2d_ctrl_pkg::*;

    localparam int WORDS = words_per_layer(MAX_K);
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ACC_AW:0]  WORDS_V   = (ACC_AW+1)'(WORDS);
    localparam logic [LAYER_W:0] MAX_NUM   = (LAYER_W+1)'(NUM_LAYERS);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 2);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT - 1);

    seq_state_e          state_q, state_d;
    logic [LAYER_W-1:0]  layer_q, layer_d;
    logic [LAYER_W-1:0]  last_q, last_d;
    logic                start_q, start_d;
    logic                err_q, err_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                acc_w0_q, acc_in_q;

    logic                busy;
    logic                ack_wr;
    logic                done_wr;
    logic                num_ok;
    logic [DATA_W-1:0]   acc_ram;
    logic [DATA_W-1:0]   word0;
    logic [DATA_W-1:0]   acc_data;
    logic                unused_acc_bits;

    assign busy    = (state_q == ST_LAUNCH) || (state_q == ST_RUN) || (state_q == ST_GAP);
    assign ack_wr  = i_acc_we && (i_acc_addr == ACC_AW'(WORD_CTRL));
    assign done_wr = ack_wr && i_acc_data[CTRL_DONE];
    assign num_ok  = (i_num_layers != '0) && (i_num_layers <= MAX_NUM);
    assign unused_acc_bits = ^{i_acc_data[31:CTRL_DONE+1], i_acc_data[CTRL_START]};

    conv2d_desc_ram #(
        .AW (LAYER_W + ACC_AW),
        .DW (DATA_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_h_we    (i_host_we && !busy),
        .i_h_addr  (i_host_addr),
        .i_h_wdata (i_host_wdata),
        .o_h_rdata (o_host_rdata),
        .i_a_addr  ({layer_q, i_acc_addr}),
        .o_a_rdata (acc_ram)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            layer_q  <= '0;
            last_q   <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            gap_q    <= '0;
            wd_q     <= '0;
            acc_w0_q <= 1'b0;
            acc_in_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            last_q   <= last_d;
            start_q  <= start_d;
            err_q    <= err_d;
            gap_q    <= gap_d;
            wd_q     <= wd_d;
            acc_w0_q <= (i_acc_addr == ACC_AW'(WORD_CTRL));
            acc_in_q <= ({1'b0, i_acc_addr} < WORDS_V);
        end
    end

    // The done-to-start window of GAP_CYCLES idle cycles includes the LAUNCH
    // cycle, so GAP itself lasts GAP_CYCLES-1 cycles (none when GAP_CYCLES=1).
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        last_d  = last_q;
        start_d = start_q;
        err_d   = err_q;
        gap_d   = gap_q;
        wd_d    = wd_q;

        if (i_host_we && busy) begin
            err_d = 1'b1;
        end

        if (i_abort && (state_q != ST_IDLE)) begin
            start_d = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_go) begin
                        if (num_ok) begin
                            err_d   = 1'b0;
                            last_d  = LAYER_W'(i_num_layers - (LAYER_W+1)'(1));
                            layer_d = '0;
                            state_d = ST_LAUNCH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    start_d = 1'b1;
                    wd_d    = '0;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (ack_wr) begin
                        start_d = 1'b0;
                    end
                    if (done_wr) begin
                        if (layer_q == last_q) begin
                            state_d = ST_FINISH;
                        end else if (GAP_CYCLES > 1) begin
                            gap_d   = GAP_LOAD;
                            state_d = ST_GAP;
                        end else begin
                            layer_d = layer_q + LAYER_W'(1);
                            state_d = ST_LAUNCH;
                        end
                    end else if ((TIMEOUT > 0) && (wd_q == WD_LIMIT)) begin
                        err_d   = 1'b1;
                        start_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        layer_d = layer_q + LAYER_W'(1);
                        state_d = ST_LAUNCH;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Word 0 is synthesised: live layer index and start flag, done reads 0.
    always_comb begin
        word0 = acc_ram;
        word0[CTRL_LAYER_LSB +: CTRL_LAYER_W] = CTRL_LAYER_W'(layer_q);
        word0[CTRL_DONE]  = 1'b0;
        word0[CTRL_START] = start_q;
        acc_data = '0;
        if (acc_in_q) begin
            acc_data = acc_w0_q ? word0 : acc_ram;
        end
    end

    assign o_acc_data = acc_data;
    assign o_busy     = busy;
    assign o_layer    = layer_q;
    assign o_err      = err_q;
    assign o_all_done = (state_q == ST_FINISH) && !i_abort;

endmodule
